// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
//
// Pipeline hazard unit for a 5-stage MIPS-style core. It detects load-use
// hazards between EX and ID, tracks occupancy of the multi-cycle
// multiply/divide unit, turns both into stall/flush controls, and counts
// the number of cycles the PC was held.
//
// Optional feature macro: HAZARD_MD_TRACK_EN
//   defined   : multiply/divide occupancy FSM is built, and ID instructions
//               that touch HI/LO stall while the unit is busy or starting.
//   undefined : no FSM; md_busy, md_done and the md hazard are tied to 0,
//               and md_start, md_div and md_use_id are ignored.
//
// Ports
//   clk, reset          clock and synchronous active-high reset
//   rs_id, rt_id        source register fields of the ID instruction
//   uses_rs_id/rt_id    ID instruction actually reads rs / rt
//   md_use_id           ID instruction is a mult/div/mfhi/mflo/mthi/mtlo
//   op_ex, rd_ex        opcode and destination register of the EX instruction
//   register_write_ex   EX instruction writes the register file
//   md_start, md_div    EX launches a multiply (md_div=0) or divide (md_div=1)
//   branch_taken_ex     branch/jump in EX resolved taken
//   stall_pc            hold the PC
//   stall_ifid          hold the IF/ID register
//   flush_ifid          clear IF/ID to a NOP
//   flush_idex          load a bubble into ID/EX
//   md_busy             multiply/divide unit occupied
//   md_done             one-cycle pulse on the last busy cycle
//   stall_cycles        saturating count of cycles with stall_pc = 1
// ---------------------------------------------------------------------------
module hazard_controller #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic        uses_rs_id,
    input  logic        uses_rt_id,
    input  logic        md_use_id,
    input  logic [5:0]  op_ex,
    input  logic [4:0]  rd_ex,
    input  logic        register_write_ex,
    input  logic        md_start,
    input  logic        md_div,
    input  logic        branch_taken_ex,
    output logic        stall_pc,
    output logic        stall_ifid,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cycles
);

    logic        is_mem_op;
    logic        load_hazard;
    logic        md_hazard;
    logic [31:0] stall_cnt;

    // Loads and stores share the memory-class opcode space; any of them
    // sitting in EX with a register write is treated as a load result that
    // is not yet available to ID.
    always_comb begin
        is_mem_op = 1'b0;
        case (op_ex)
            6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37,
            6'd38, 6'd40, 6'd41, 6'd42, 6'd43, 6'd46: is_mem_op = 1'b1;
            default:                                  is_mem_op = 1'b0;
        endcase
    end

    // r0 is hard-wired to zero, so a "write" to it never creates a hazard.
    assign load_hazard = is_mem_op && register_write_ex && (rd_ex != 5'd0) &&
                         ((uses_rs_id && (rd_ex == rs_id)) ||
                          (uses_rt_id && (rd_ex == rt_id)));

`ifdef HAZARD_MD_TRACK_EN
    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_t;

    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    md_state_t  md_state;
    logic [5:0] md_cnt;

    // Occupancy FSM. md_cnt counts down the remaining busy cycles after the
    // current one; a new md_start is only accepted from idle, so a start
    // arriving on the final busy cycle is dropped rather than chained.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_state <= MD_IDLE;
            md_cnt   <= 6'd0;
        end else begin
            case (md_state)
                MD_IDLE: begin
                    if (md_start) begin
                        md_state <= MD_BUSY;
                        md_cnt   <= md_div ? DIV_LOAD : MUL_LOAD;
                    end
                end
                MD_BUSY: begin
                    if (md_cnt == 6'd0) begin
                        md_state <= MD_IDLE;
                    end else begin
                        md_cnt <= md_cnt - 6'd1;
                    end
                end
                default: begin
                    md_state <= MD_IDLE;
                    md_cnt   <= 6'd0;
                end
            endcase
        end
    end

    // Masking with reset keeps busy/done low while reset is held, so an
    // aborted operation never shows a done pulse.
    assign md_busy   = (md_state == MD_BUSY) && !reset;
    assign md_done   = md_busy && (md_cnt == 6'd0);
    assign md_hazard = md_use_id && (md_busy || md_start);
`else
    logic md_inputs_unused;

    assign md_inputs_unused = md_start ^ md_div ^ md_use_id;
    assign md_busy          = 1'b0;
    assign md_done          = 1'b0;
    assign md_hazard        = 1'b0;
`endif

    // A taken branch squashes both younger instructions, so any stall they
    // would have caused is meaningless and the front end must keep moving.
    always_comb begin
        stall_pc   = load_hazard || md_hazard;
        stall_ifid = load_hazard || md_hazard;
        flush_idex = load_hazard || md_hazard;
        flush_ifid = 1'b0;
        if (branch_taken_ex) begin
            stall_pc   = 1'b0;
            stall_ifid = 1'b0;
            flush_idex = 1'b1;
            flush_ifid = 1'b1;
        end
    end

    // Stall cycle counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'd0;
        end else if (stall_pc && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_hazard_controller
//
// Directed bench for hazard_controller. A driver applies one input vector
// per clock (just after the rising edge) and queues the hand-computed
// response; a monitor on the falling edge pops each entry and compares it
// with what the design presents. Expectations for the multiply/divide
// outputs follow HAZARD_MD_TRACK_EN.
// ---------------------------------------------------------------------------
module tb_hazard_controller;

`ifdef HAZARD_MD_TRACK_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    // {stall_pc, stall_ifid, flush_ifid, flush_idex}
    localparam logic [3:0] NONE  = 4'b0000;
    localparam logic [3:0] STALL = 4'b1101;
    localparam logic [3:0] FLUSH = 4'b0011;

    typedef struct packed {
        logic       rst;
        logic [5:0] op;
        logic [4:0] rd;
        logic       rw;
        logic [4:0] rs;
        logic       us;
        logic [4:0] rt;
        logic       ut;
        logic       mu;
        logic       ms;
        logic       mdv;
        logic       br;
    } stim_t;

    typedef struct packed {
        logic [3:0]  flags;
        logic        busy;
        logic        done;
        logic [31:0] cnt;
        logic [7:0]  cycle;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [4:0]  rs_id;
    logic [4:0]  rt_id;
    logic        uses_rs_id;
    logic        uses_rt_id;
    logic        md_use_id;
    logic [5:0]  op_ex;
    logic [4:0]  rd_ex;
    logic        register_write_ex;
    logic        md_start;
    logic        md_div;
    logic        branch_taken_ex;
    logic        stall_pc;
    logic        stall_ifid;
    logic        flush_ifid;
    logic        flush_idex;
    logic        md_busy;
    logic        md_done;
    logic [31:0] stall_cycles;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   cycle_no = 0;

    hazard_controller #(
        .MUL_CYCLES(4),
        .DIV_CYCLES(32)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rs_id            (rs_id),
        .rt_id            (rt_id),
        .uses_rs_id       (uses_rs_id),
        .uses_rt_id       (uses_rt_id),
        .md_use_id        (md_use_id),
        .op_ex            (op_ex),
        .rd_ex            (rd_ex),
        .register_write_ex(register_write_ex),
        .md_start         (md_start),
        .md_div           (md_div),
        .branch_taken_ex  (branch_taken_ex),
        .stall_pc         (stall_pc),
        .stall_ifid       (stall_ifid),
        .flush_ifid       (flush_ifid),
        .flush_idex       (flush_idex),
        .md_busy          (md_busy),
        .md_done          (md_done),
        .stall_cycles     (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t idleStim();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t loadStim(input logic [5:0] op, input logic [4:0] rd,
                                       input logic rw, input logic [4:0] rs,
                                       input logic us, input logic [4:0] rt,
                                       input logic ut);
        stim_t s;
        s    = '0;
        s.op = op;
        s.rd = rd;
        s.rw = rw;
        s.rs = rs;
        s.us = us;
        s.rt = rt;
        s.ut = ut;
        return s;
    endfunction

    // One cycle of stimulus plus the response expected while it is applied.
    task automatic applyStimulus(input stim_t s, input logic [3:0] flags,
                                 input logic busy, input logic done,
                                 input logic [31:0] cnt);
        exp_t e;
        @(posedge clk);
        #1;
        reset             = s.rst;
        op_ex             = s.op;
        rd_ex             = s.rd;
        register_write_ex = s.rw;
        rs_id             = s.rs;
        uses_rs_id        = s.us;
        rt_id             = s.rt;
        uses_rt_id        = s.ut;
        md_use_id         = s.mu;
        md_start          = s.ms;
        md_div            = s.mdv;
        branch_taken_ex   = s.br;
        e.flags = flags;
        e.busy  = busy;
        e.done  = done;
        e.cnt   = cnt;
        e.cycle = 8'(cycle_no);
        exp_q.push_back(e);
        cycle_no++;
    endtask

    task automatic checkOutput(input string name, input int cyc,
                               input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("[TB] FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
        end
    endtask

    // Monitor: every cycle the design presents a response; compare it with
    // the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput("stall_pc",     int'(e.cycle), 32'(stall_pc),   32'(e.flags[3]));
            checkOutput("stall_ifid",   int'(e.cycle), 32'(stall_ifid), 32'(e.flags[2]));
            checkOutput("flush_ifid",   int'(e.cycle), 32'(flush_ifid), 32'(e.flags[1]));
            checkOutput("flush_idex",   int'(e.cycle), 32'(flush_idex), 32'(e.flags[0]));
            checkOutput("md_busy",      int'(e.cycle), 32'(md_busy),    32'(e.busy));
            checkOutput("md_done",      int'(e.cycle), 32'(md_done),    32'(e.done));
            checkOutput("stall_cycles", int'(e.cycle), stall_cycles,    e.cnt);
        end
    end

    initial begin
        stim_t s;
        stim_t lu;
        int    wait_cnt;

        reset             = 1'b1;
        op_ex             = '0;
        rd_ex             = '0;
        register_write_ex = 1'b0;
        rs_id             = '0;
        uses_rs_id        = 1'b0;
        rt_id             = '0;
        uses_rt_id        = 1'b0;
        md_use_id         = 1'b0;
        md_start          = 1'b0;
        md_div            = 1'b0;
        branch_taken_ex   = 1'b0;

        lu = loadStim(6'd35, 5'd8, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0);

        // Reset state and load-use detection variants
        s = idleStim(); s.rst = 1'b1;
        applyStimulus(s, NONE, 1'b0, 1'b0, 32'd0);
        applyStimulus(idleStim(), NONE, 1'b0, 1'b0, 32'd0);
        applyStimulus(lu, STALL, 1'b0, 1'b0, 32'd0);
        applyStimulus(idleStim(), NONE, 1'b0, 1'b0, 32'd1);
        applyStimulus(loadStim(6'd35, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0), NONE, 1'b0, 1'b0, 32'd1);
        applyStimulus(idleStim(), NONE, 1'b0, 1'b0, 32'd1);
        applyStimulus(loadStim(6'd32, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1), STALL, 1'b0, 1'b0, 32'd1);
        applyStimulus(loadStim(6'd46, 5'd9, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0), STALL, 1'b0, 1'b0, 32'd2);
        applyStimulus(loadStim(6'd39, 5'd9, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0), NONE, 1'b0, 1'b0, 32'd3);
        applyStimulus(loadStim(6'd35, 5'd9, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0), NONE, 1'b0, 1'b0, 32'd3);
        applyStimulus(loadStim(6'd35, 5'd9, 1'b1, 5'd9, 1'b0, 5'd9, 1'b0), NONE, 1'b0, 1'b0, 32'd3);

        // Branch overriding a load-use hazard, and a branch on its own
        s = lu; s.br = 1'b1;
        applyStimulus(s, FLUSH, 1'b0, 1'b0, 32'd3);
        s = idleStim(); s.br = 1'b1;
        applyStimulus(s, FLUSH, 1'b0, 1'b0, 32'd3);
        applyStimulus(idleStim(), NONE, 1'b0, 1'b0, 32'd3);

        // Reset with a hazard present: outputs still follow, counter clears
        s = lu; s.rst = 1'b1;
        applyStimulus(s, STALL, 1'b0, 1'b0, 32'd3);
        applyStimulus(idleStim(), NONE, 1'b0, 1'b0, 32'd0);

        // Multiply with a dependent HI/LO reader held in ID; extra starts
        // during busy and on the done cycle are ignored
        s = idleStim(); s.mu = 1'b1; s.ms = 1'b1;
        applyStimulus(s, MD_EN ? STALL : NONE, 1'b0, 1'b0, 32'd0);
        s = idleStim(); s.mu = 1'b1;
        applyStimulus(s, MD_EN ? STALL : NONE, MD_EN, 1'b0, MD_EN ? 32'd1 : 32'd0);
        s = idleStim(); s.mu = 1'b1; s.ms = 1'b1; s.mdv = 1'b1;
        applyStimulus(s, MD_EN ? STALL : NONE, MD_EN, 1'b0, MD_EN ? 32'd2 : 32'd0);
        s = idleStim(); s.mu = 1'b1;
        applyStimulus(s, MD_EN ? STALL : NONE, MD_EN, 1'b0, MD_EN ? 32'd3 : 32'd0);
        s = idleStim(); s.mu = 1'b1; s.ms = 1'b1;
        applyStimulus(s, MD_EN ? STALL : NONE, MD_EN, MD_EN, MD_EN ? 32'd4 : 32'd0);
        applyStimulus(idleStim(), NONE, 1'b0, 1'b0, MD_EN ? 32'd5 : 32'd0);

        // Divide aborted by reset after 10 busy cycles; start in the reset
        // cycle must not launch a new operation
        s = idleStim(); s.ms = 1'b1; s.mdv = 1'b1;
        applyStimulus(s, NONE, 1'b0, 1'b0, MD_EN ? 32'd5 : 32'd0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(idleStim(), NONE, MD_EN, 1'b0, MD_EN ? 32'd5 : 32'd0);
        end
        s = idleStim(); s.rst = 1'b1; s.ms = 1'b1;
        applyStimulus(s, NONE, 1'b0, 1'b0, MD_EN ? 32'd5 : 32'd0);
        applyStimulus(idleStim(), NONE, 1'b0, 1'b0, 32'd0);
        applyStimulus(idleStim(), NONE, 1'b0, 1'b0, 32'd0);

        // Multiply launched in the same cycle as a taken branch
        s = idleStim(); s.br = 1'b1; s.ms = 1'b1;
        applyStimulus(s, FLUSH, 1'b0, 1'b0, 32'd0);
        applyStimulus(idleStim(), NONE, MD_EN, 1'b0, 32'd0);
        applyStimulus(idleStim(), NONE, MD_EN, 1'b0, 32'd0);
        applyStimulus(idleStim(), NONE, MD_EN, 1'b0, 32'd0);
        applyStimulus(idleStim(), NONE, MD_EN, MD_EN, 32'd0);
        applyStimulus(idleStim(), NONE, 1'b0, 1'b0, 32'd0);

        // Saturation: preload the counter just below max between samples
        #6;
        force dut.stall_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt;
        applyStimulus(lu, STALL, 1'b0, 1'b0, 32'hFFFF_FFFD);
        applyStimulus(lu, STALL, 1'b0, 1'b0, 32'hFFFF_FFFE);
        applyStimulus(lu, STALL, 1'b0, 1'b0, 32'hFFFF_FFFF);
        applyStimulus(idleStim(), NONE, 1'b0, 1'b0, 32'hFFFF_FFFF);
        s = idleStim(); s.rst = 1'b1;
        applyStimulus(s, NONE, 1'b0, 1'b0, 32'hFFFF_FFFF);
        applyStimulus(idleStim(), NONE, 1'b0, 1'b0, 32'd0);

        // Drain the scoreboard with a bounded wait
        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
